// File: rtl/data_pipe.sv
// data_pipe: DEPTH-stage valid/ready pipeline register with stall back-pressure,
// bubble collapsing and synchronous flush. Reset is synchronous, active-low.
// Optional macro DATA_PIPE_DATA_RST_EN: data registers are also cleared by
// reset and flush (otherwise only valid bits and count are).

// One pipeline stage: a valid bit and a data register.
module data_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             adv,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Valid bit: set on load, cleared when the word moves on without a refill.
    always_ff @(posedge clk) begin
        if (!rst_n || flush)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (adv)
            valid <= 1'b0;
    end

`ifdef DATA_PIPE_DATA_RST_EN
    // Data register, cleared by reset and flush.
    always_ff @(posedge clk) begin
        if (!rst_n || flush)
            data <= '0;
        else if (load)
            data <= din;
    end
`else
    // Data register without reset; only meaningful while valid is set.
    always_ff @(posedge clk) begin
        if (load)
            data <= din;
    end
`endif

endmodule

module data_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0][WIDTH-1:0] din;
    logic                        full_above;
    logic                        in_xfer;
    logic                        out_xfer;

    // A stage advances when the output is being taken or any stage
    // downstream of it is empty (bubble collapsing). Walking from the output
    // side with an accumulator avoids a self-referencing adv chain.
    always_comb begin
        adv        = '0;
        full_above = 1'b1;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            adv[s]     = out_ready | ~full_above;
            full_above = full_above & v[s];
        end
    end

    // Input handshake is blocked during reset and flush.
    always_comb begin
        in_ready = rst_n & ~flush & (~v[0] | adv[0]);
        in_xfer  = in_valid & in_ready;
        out_xfer = v[DEPTH-1] & out_ready;
    end

    // Stage 0 loads the input word; later stages load from their predecessor.
    always_comb begin
        load    = '0;
        din     = '0;
        load[0] = in_xfer;
        din[0]  = in_data;
        for (int s = 1; s < DEPTH; s++) begin
            load[s] = v[s-1] & adv[s-1];
            din[s]  = d[s-1];
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        data_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .load  (load[s]),
            .adv   (adv[s]),
            .din   (din[s]),
            .valid (v[s]),
            .data  (d[s])
        );
    end

    // Occupancy tracks transfers rather than recounting valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n || flush)
            count <= '0;
        else
            count <= count + CW'(in_xfer) - CW'(out_xfer);
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_data_pipe.sv
// Bench for data_pipe: four instances (DEPTH 1..4) share stimulus; a
// queue-position model of each pipe predicts handshake, count and data.
module tb_data_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        ir[4];
    logic        ov[4];
    logic [31:0] od[4];
    logic [3:0]  cnt[4];
    logic [0:0]  c1;
    logic [1:0]  c2, c3;
    logic [2:0]  c4;

    int checks = 0;
    int failures = 0;
    int nprint = 0;

    // model: per pipe, words oldest-first with their stage index
    int          dep[4] = '{1, 2, 3, 4};
    int          mn[4];
    int          mp[4][8];
    logic [31:0] md[4][8];

    always #5 clk = ~clk;

    data_pipe #(.WIDTH(32), .DEPTH(1)) u1 (.clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .count(c1));
    data_pipe #(.WIDTH(32), .DEPTH(2)) u2 (.clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .count(c2));
    data_pipe #(.WIDTH(32), .DEPTH(3)) u3 (.clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .count(c3));
    data_pipe #(.WIDTH(32), .DEPTH(4)) u4 (.clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data), .out_valid(ov[3]),
        .out_ready(out_ready), .out_data(od[3]), .count(c4));

    assign cnt[0] = {3'b0, c1};
    assign cnt[1] = {2'b0, c2};
    assign cnt[2] = {2'b0, c3};
    assign cnt[3] = {1'b0, c4};

    function automatic logic m_rdy(int k);
        return rst_n && !flush && (mn[k] < dep[k] || out_ready);
    endfunction

    function automatic logic m_ov(int k);
        return mn[k] > 0 && mp[k][0] == dep[k] - 1;
    endfunction

    // advance every model by one clock edge using the current inputs
    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            logic push, pop;
            int   lim;
            if (!rst_n || flush) begin
                mn[k] = 0;
            end else begin
                push = in_valid && m_rdy(k);
                pop  = m_ov(k) && out_ready;
                if (pop) begin
                    for (int i = 1; i < mn[k]; i++) begin
                        mp[k][i-1] = mp[k][i];
                        md[k][i-1] = md[k][i];
                    end
                    mn[k]--;
                end
                lim = dep[k] - 1;
                for (int i = 0; i < mn[k]; i++) begin
                    mp[k][i] = (mp[k][i] + 1 < lim) ? mp[k][i] + 1 : lim;
                    lim = mp[k][i] - 1;
                end
                if (push) begin
                    mp[k][mn[k]] = 0;
                    md[k][mn[k]] = in_data;
                    mn[k]++;
                end
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        clk_step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b1;
        clk_step();
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ov[k] !== 1'b0 || cnt[k] !== 4'd0 || ir[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset d%0d: out_valid=%b count=%0d in_ready=%b, want 0 0 0",
                             k + 1, ov[k], cnt[k], ir[k]);
                end
            end
            clk_step();
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ir[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset_release d%0d: in_ready=%b want 1", k + 1, ir[k]);
            end
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in_data  = 32'(c + 1);
            #1;
            if (c < 8) begin
                checks++;
                if (ir[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_ready c%0d: in_ready=%b want 1", c, ir[1]);
                end
            end
            checks++;
            if (c >= 2 && c < 10) begin
                if (ov[1] !== 1'b1 || od[1] !== 32'(c - 1)) begin
                    failures++;
                    $display("FAIL stream_data c%0d: valid=%b data=%h want 1 %h",
                             c, ov[1], od[1], 32'(c - 1));
                end
            end else if (ov[1] !== 1'b0) begin
                failures++;
                $display("FAIL stream_idle c%0d: out_valid=%b want 0", c, ov[1]);
            end
            if (c >= 2 && c <= 8) begin
                checks++;
                if (cnt[1] !== 4'd2) begin
                    failures++;
                    $display("FAIL stream_count c%0d: count=%0d want 2", c, cnt[1]);
                end
            end
            clk_step();
        end
    endtask

    task automatic test_stall_fill();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hA + 32'(i);
            #1;
            checks++;
            if (ir[2] !== 1'b1) begin
                failures++;
                $display("FAIL fill_accept %0d: in_ready=%b want 1", i, ir[2]);
            end
            clk_step();
        end
        in_data = 32'hD;
        #1;
        checks++;
        if (ir[2] !== 1'b0 || cnt[2] !== 4'd3 || ov[2] !== 1'b1 || od[2] !== 32'hA) begin
            failures++;
            $display("FAIL fill_full: in_ready=%b count=%0d valid=%b data=%h want 0 3 1 a",
                     ir[2], cnt[2], ov[2], od[2]);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (ir[2] !== 1'b1) begin
            failures++;
            $display("FAIL fill_pushpop: in_ready=%b want 1", ir[2]);
        end
        clk_step();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (ov[2] !== 1'b1 || od[2] !== 32'hB + 32'(j) || cnt[2] !== 4'(3 - j)) begin
                failures++;
                $display("FAIL fill_drain %0d: valid=%b data=%h count=%0d want 1 %h %0d",
                         j, ov[2], od[2], cnt[2], 32'hB + 32'(j), 3 - j);
            end
            clk_step();
        end
        #1;
        checks++;
        if (ov[2] !== 1'b0 || cnt[2] !== 4'd0) begin
            failures++;
            $display("FAIL fill_empty: valid=%b count=%0d want 0 0", ov[2], cnt[2]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h77; clk_step();
        in_data = 32'h78; clk_step();
        in_data = 32'h55; flush = 1'b1;
        #1;
        checks++;
        if (cnt[1] !== 4'd2 || ir[1] !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle: count=%0d in_ready=%b want 2 0", cnt[1], ir[1]);
        end
        clk_step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (cnt[1] !== 4'd0 || ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
            failures++;
            $display("FAIL flush_after: count=%0d valid=%b in_ready=%b want 0 0 1",
                     cnt[1], ov[1], ir[1]);
        end
`ifdef DATA_PIPE_DATA_RST_EN
        checks++;
        if (od[1] !== 32'h0) begin
            failures++;
            $display("FAIL flush_data: out_data=%h want 0", od[1]);
        end
`endif
    endtask

    task automatic test_bubble();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; clk_step();
        in_valid = 1'b0; clk_step(); clk_step();
        in_valid = 1'b1; in_data = 32'h22; clk_step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) clk_step();
        #1;
        checks++;
        if (cnt[3] !== 4'd2 || ov[3] !== 1'b1 || od[3] !== 32'h11) begin
            failures++;
            $display("FAIL bubble_held: count=%0d valid=%b data=%h want 2 1 11",
                     cnt[3], ov[3], od[3]);
        end
        out_ready = 1'b1;
        clk_step();
        #1;
        checks++;
        if (ov[3] !== 1'b1 || od[3] !== 32'h22) begin
            failures++;
            $display("FAIL bubble_second: valid=%b data=%h want 1 22", ov[3], od[3]);
        end
        clk_step();
        #1;
        checks++;
        if (ov[3] !== 1'b0 || cnt[3] !== 4'd0) begin
            failures++;
            $display("FAIL bubble_empty: valid=%b count=%0d want 0 0", ov[3], cnt[3]);
        end
    endtask

    task automatic test_depth1();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 5);
            in_data  = 32'h100 + 32'(c);
            #1;
            if (c < 5) begin
                checks++;
                if (ir[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL d1_ready c%0d: in_ready=%b want 1", c, ir[0]);
                end
            end
            if (c >= 1) begin
                checks++;
                if (ov[0] !== 1'b1 || od[0] !== 32'h100 + 32'(c - 1) || cnt[0] !== 4'd1) begin
                    failures++;
                    $display("FAIL d1_data c%0d: valid=%b data=%h count=%0d want 1 %h 1",
                             c, ov[0], od[0], cnt[0], 32'h100 + 32'(c - 1));
                end
            end
            clk_step();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10000; n++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < ((n / 1000) % 2 ? 8 : 4));
            in_data   = $urandom;
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ir[k] !== m_rdy(k) || ov[k] !== m_ov(k) || cnt[k] !== 4'(mn[k]) ||
                    (m_ov(k) && od[k] !== md[k][0])) begin
                    failures++;
                    if (nprint < 20) begin
                        nprint++;
                        $display("FAIL random d%0d n%0d: rdy=%b valid=%b count=%0d data=%h want %b %b %0d %h",
                                 k + 1, n, ir[k], ov[k], cnt[k], od[k],
                                 m_rdy(k), m_ov(k), mn[k], md[k][0]);
                    end
                end
            end
            clk_step();
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) mn[k] = 0;
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush();
        test_bubble();
        test_depth1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_pipe.md
# data_pipe

Parametrised multi-stage pipeline register with a valid/ready handshake, stall back-pressure, bubble collapsing and synchronous flush. It replaces the plain single-stage 32-bit datapath latch between multi-cycle CPU units, such as the memory data register and the ALU result register. It also covers paths that must stall or be squashed on a branch or exception. Throughput is one word per cycle; latency is DEPTH cycles when the pipe is unstalled.

## Interface
- WIDTH, 32: data word width in bits (1..64).
- DEPTH, 2: number of register stages (1..8).
- CW, $clog2(DEPTH+1): width of the occupancy count. Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- flush  in  1  synchronous squash of all stages.
- in_valid  in  1  producer presents in_data.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  1  last stage holds a valid word.
- out_ready  in  1  consumer takes out_data this cycle.
- out_data  out  WIDTH  last-stage word.
- count  out  CW  number of valid stages, 0..DEPTH.

## Operation
- State:
  - Each stage s (0 = input side, DEPTH-1 = output side) holds one valid bit v[s] and one data register d[s].
- Stage advance:
  - The last stage advances when out_ready=1.
  - Any other stage s advances when v[s+1]=0, or when stage s+1 itself advances.
- Stage load:
  - Stage s loads from stage s-1 when stage s-1 is valid and advancing.
  - Stage 0 loads in_data when in_valid and in_ready are both 1.
  - A stage that advances and is not loaded has its valid bit cleared.
  - A valid stage that does not advance holds its contents (stall).
- Bubble collapsing:
  - An empty stage always accepts from the stage upstream of it.
  - A stalled output therefore lets the pipe fill to DEPTH words before in_ready drops.
- in_ready:
  - in_ready = rst_n & ~flush & (~v[0] | stage 0 advances).
  - It is combinational from state, out_ready and flush.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - out_valid = v[DEPTH-1] and out_data = d[DEPTH-1]. Both are registered outputs, with no combinational path from the inputs.
- count:
  - count is the registered number of set valid bits.
  - Next value = count + input transfer − output transfer.
- flush:
  - flush=1 clears every valid bit at the next edge.
  - in_ready is 0 during the flush cycle, so no word is accepted.
  - An output transfer in the flush cycle still completes, because out_valid was already asserted.
- Reset:
  - While rst_n=0, all valid bits clear at the edge and count goes to 0.
  - in_ready is 0 during reset.
  - Reset has priority over flush.
- DEPTH=1: the block degenerates to a single register with a handshake. Simultaneous input and output transfers are allowed, giving full throughput.

## Timing
- Reset values: out_valid=0, count=0, in_ready=0 while rst_n=0. in_ready is 1 in the first cycle after reset release with flush=0.
- out_data after reset is 0 with DATA_PIPE_DATA_RST_EN defined, and don't-care without it.
- Latency: a word accepted at edge N appears as out_valid at edge N+DEPTH−1, i.e. visible during cycle N+DEPTH, provided out_ready stays 1.
- Throughput: one word per cycle sustained when in_valid=out_ready=1.
- Full pipe (count=DEPTH) with out_ready=0 gives in_ready=0. With out_ready=1, in_ready=1 in the same cycle (simultaneous push and pop).
- Empty pipe (count=0): out_valid=0, and out_ready is ignored.
- A flush and a reset asserted mid-transfer both take effect at the next edge, with nothing accepted in that cycle.

## Configuration
- DATA_PIPE_DATA_RST_EN defined:
  - All d[s] reset to 0 on rst_n=0.
  - All d[s] are also cleared to 0 by flush.
- DATA_PIPE_DATA_RST_EN undefined:
  - Only the valid bits and count are reset or flushed.
  - The data registers have no reset, for smaller and faster flops.
  - out_data is meaningful only while out_valid=1.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, count=0, in_ready=0 throughout. The first cycle after release shows in_ready=1.
- Streaming, DEPTH=2: push 0x00000001..0x00000008 on consecutive cycles with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, first one 2 cycles after the first accept, count steady at 2.
- Stall fill, DEPTH=3: hold out_ready=0 and push 0xA, 0xB, 0xC, 0xD -> 0xA..0xC accepted, count=3, in_ready=0 on 0xD. Raising out_ready drains 0xA, 0xB, 0xC in order with 0xD accepted in the first drain cycle, and no word is lost or duplicated.
- Flush: with count=2, pulse flush for 1 cycle while in_valid=1 and data=0x55 -> in_ready=0 in that cycle, and the next cycle shows count=0 and out_valid=0. With the macro defined, out_data=0.
- Bubble collapse, DEPTH=4: push 0x11, idle 2 cycles, push 0x22, with out_ready=0 -> count=2, and 0x11 and 0x22 leave on consecutive cycles once out_ready=1.
- Random: random in_valid/out_ready for 10k cycles against a scoreboard queue -> in-order output and count equal to the queue size every cycle.
